i2s_target_rx: RTL and testbench

- I2S target-side (clock-follower) receiver: the other end of the clock-master link that drives MCLK/LRCK/SCLK/SDO.
- Accepts externally driven sclk/lrck/sdi, oversamples them on the local system clock and deserializes one stereo frame.
- Presents the frame as a left/right pair with a valid/ready handshake, plus overflow and framing-error status.
- Sits between the PMOD pins and the effects pipe whenever the board is not the I2S clock source.

---
 rtl/i2s_target_rx.sv | 217 +++++++++++++++++++++
 tb/tb_i2s_target_rx.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_target_rx.sv
// i2s_target_rx: I2S clock-follower receiver.
//
// Oversamples an externally driven sclk/lrck/sdi on the local clock,
// deserializes one stereo frame and hands it out as a left/right pair
// over a valid/ready handshake.
//
// Ports:
//   clk        system clock, at least 4x the SCLK frequency
//   rst_n      active-low asynchronous reset
//   sclk       external bit clock (asynchronous to clk)
//   lrck       external word select, 0 = left, 1 = right
//   sdi        external serial data
//   left_o     left sample, two's complement
//   right_o    right sample, two's complement
//   vld_o      frame valid, held until accepted
//   rdy_i      consumer ready; transfer when vld_o && rdy_i
//   ovf_o      sticky: a completed frame was dropped
//   ovf_clr_i  single-cycle clear for ovf_o (a same-cycle drop wins)
//   frm_err_o  one-cycle pulse on a framing violation
//   lock_o     high after the first good frame, low in HUNT
//
// state | meaning
// HUNT  | waiting for a 1->0 LRCK change to align on a left slot
// LEFT  | capturing the left slot
// RIGHT | capturing the right slot; frame completes on the next 1->0 change

module i2s_target_rx #(
    parameter int DATA_W      = 24,
    parameter int SLOT_W      = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sclk,
    input  logic              lrck,
    input  logic              sdi,
    output logic [DATA_W-1:0] left_o,
    output logic [DATA_W-1:0] right_o,
    output logic              vld_o,
    input  logic              rdy_i,
    output logic              ovf_o,
    input  logic              ovf_clr_i,
    output logic              frm_err_o,
    output logic              lock_o
);

    typedef enum logic [1:0] {HUNT, LEFT, RIGHT} state_t;

    // k counts sre events within a slot; K_LAST is the index of the final
    // bit of a correctly sized slot.
    localparam logic [5:0] K_LAST = 6'(SLOT_W - 1);
    localparam logic [5:0] K_DATA = 6'(DATA_W);
    localparam logic [5:0] K_MAX  = 6'd63;

    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] lrck_sync;
    logic [SYNC_STAGES-1:0] sdi_sync;
    logic                   sclk_prev;
    logic                   lrck_prev;
    logic [5:0]             k;
    logic [DATA_W-1:0]      shift_q;
    logic [DATA_W-1:0]      left_hold;
    state_t                 state_q;
    state_t                 state_d;

    logic sclk_s;
    logic lrck_s;
    logic sdi_s;
    logic sre;
    logic lr_chg;
    logic err;
    logic latch_left;
    logic frame_done;
    logic load;
    logic drop;

    assign sclk_s = sclk_sync[SYNC_STAGES-1];
    assign lrck_s = lrck_sync[SYNC_STAGES-1];
    assign sdi_s  = sdi_sync[SYNC_STAGES-1];
    assign sre    = sclk_s & ~sclk_prev;
    assign lr_chg = sre & (lrck_s ^ lrck_prev);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync <= '0;
            lrck_sync <= '0;
            sdi_sync  <= '0;
            sclk_prev <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
            lrck_sync <= {lrck_sync[SYNC_STAGES-2:0], lrck};
            sdi_sync  <= {sdi_sync[SYNC_STAGES-2:0], sdi};
            sclk_prev <= sclk_s;
        end
    end

    // Bit position and data capture. k=0 carries the previous slot's
    // trailing bit, so data shifts only while the new k lands in 1..DATA_W.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lrck_prev <= 1'b0;
            k         <= '0;
            shift_q   <= '0;
            left_hold <= '0;
        end else begin
            if (sre) begin
                lrck_prev <= lrck_s;
                if (lr_chg) begin
                    k <= '0;
                end else if (k != K_MAX) begin
                    k <= k + 6'd1;
                end
                if (!lr_chg && (k < K_DATA)) begin
                    shift_q <= {shift_q[DATA_W-2:0], sdi_s};
                end
            end
            if (latch_left) begin
                left_hold <= shift_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= HUNT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        err        = 1'b0;
        latch_left = 1'b0;
        frame_done = 1'b0;
        if (sre) begin
            case (state_q)
                HUNT: begin
                    if (lr_chg && !lrck_s) begin
                        state_d = LEFT;
                    end
                end
                LEFT: begin
                    if (lr_chg) begin
                        if (k == K_LAST) begin
                            latch_left = 1'b1;
                            state_d    = RIGHT;
                        end else begin
                            err     = 1'b1;
                            state_d = HUNT;
                        end
                    end else if (k == K_LAST) begin
                        // Slot overran SLOT_W without a word-select change.
                        err     = 1'b1;
                        state_d = HUNT;
                    end
                end
                RIGHT: begin
                    if (lr_chg) begin
                        if (k == K_LAST) begin
                            frame_done = 1'b1;
                            state_d    = LEFT;
                        end else begin
                            err     = 1'b1;
                            state_d = HUNT;
                        end
                    end else if (k == K_LAST) begin
                        err     = 1'b1;
                        state_d = HUNT;
                    end
                end
                default: begin
                    state_d = HUNT;
                end
            endcase
        end
    end

    // A completing frame replaces the held one when the slot is free or
    // being accepted in this same cycle; otherwise it is dropped.
    assign load = frame_done & (~vld_o | rdy_i);
    assign drop = frame_done & vld_o & ~rdy_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            left_o    <= '0;
            right_o   <= '0;
            vld_o     <= 1'b0;
            ovf_o     <= 1'b0;
            frm_err_o <= 1'b0;
            lock_o    <= 1'b0;
        end else begin
            if (load) begin
                left_o  <= left_hold;
                right_o <= shift_q;
                vld_o   <= 1'b1;
            end else if (vld_o && rdy_i) begin
                vld_o <= 1'b0;
            end

            if (drop) begin
                ovf_o <= 1'b1;
            end else if (ovf_clr_i) begin
                ovf_o <= 1'b0;
            end

            frm_err_o <= err;

            if ((state_d == HUNT) && (state_q != HUNT)) begin
                lock_o <= 1'b0;
            end else if (frame_done) begin
                lock_o <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_i2s_target_rx.sv
// Directed bench for i2s_target_rx: drives clk-aligned I2S bit streams and
// compares the outputs against hand-computed frames.

module tb_i2s_target_rx;

    localparam int DW = 24;
    localparam int SW = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          sclk;
    logic          lrck;
    logic          sdi;
    logic          rdy_i;
    logic          ovf_clr_i;
    logic [DW-1:0] left_o;
    logic [DW-1:0] right_o;
    logic          vld_o;
    logic          ovf_o;
    logic          frm_err_o;
    logic          lock_o;

    int vec  = 0;
    int miss = 0;
    int err_cnt   = 0;
    int vld_rises = 0;
    bit vld_d     = 1'b0;
    bit open_left = 1'b0;
    logic [DW-1:0] acc_l[$];
    logic [DW-1:0] acc_r[$];

    always #5 clk = ~clk;

    i2s_target_rx #(.DATA_W(DW), .SLOT_W(SW), .SYNC_STAGES(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sclk      (sclk),
        .lrck      (lrck),
        .sdi       (sdi),
        .left_o    (left_o),
        .right_o   (right_o),
        .vld_o     (vld_o),
        .rdy_i     (rdy_i),
        .ovf_o     (ovf_o),
        .ovf_clr_i (ovf_clr_i),
        .frm_err_o (frm_err_o),
        .lock_o    (lock_o)
    );

    // Observer: records every accepted frame, error pulses and vld rises.
    always @(negedge clk) begin
        if (rst_n) begin
            if (vld_o && rdy_i) begin
                acc_l.push_back(left_o);
                acc_r.push_back(right_o);
            end
            if (frm_err_o) err_cnt++;
            if (vld_o && !vld_d) vld_rises++;
        end
        vld_d = vld_o;
    end

    // One SCLK period = 8 clk. Optionally pulses rdy_i for exactly the clk
    // edge where the DUT acts on this bit's rising edge (3rd edge after it).
    task automatic send_bit(input logic lr, input logic d, input bit rdy_pulse);
        sclk = 1'b0;
        lrck = lr;
        sdi  = d;
        repeat (4) @(posedge clk);
        #1 sclk = 1'b1;
        if (rdy_pulse) begin
            repeat (2) @(posedge clk);
            #1 rdy_i = 1'b1;
            @(posedge clk);
            #1 rdy_i = 1'b0;
            @(posedge clk);
            #1;
        end else begin
            repeat (4) @(posedge clk);
            #1;
        end
    endtask

    task automatic send_frame(input logic [DW-1:0] l, input logic [DW-1:0] r,
                              input int lslot, input int rslot);
        for (int i = 0; i < lslot; i++) begin
            if (!(i == 0 && open_left))
                send_bit(1'b0, (i >= 1 && i <= DW) ? l[DW-i] : 1'b0, 1'b0);
        end
        open_left = 1'b0;
        for (int i = 0; i < rslot; i++)
            send_bit(1'b1, (i >= 1 && i <= DW) ? r[DW-i] : 1'b0, 1'b0);
    endtask

    // First bit of the next left slot: completes the pending frame.
    task automatic close_frame(input bit rdy_pulse);
        send_bit(1'b0, 1'b0, rdy_pulse);
        open_left = 1'b1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        open_left = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        sclk = 1'b0; lrck = 1'b0; sdi = 1'b0; rdy_i = 1'b0; ovf_clr_i = 1'b0;
        @(posedge clk);
        #1;
        apply_reset();
        vec++; if (vld_o !== 1'b0) begin miss++; $display("FAIL rst_vld got %b exp 0", vld_o); end
        vec++; if (left_o !== '0) begin miss++; $display("FAIL rst_left got %h exp 0", left_o); end
        vec++; if (right_o !== '0) begin miss++; $display("FAIL rst_right got %h exp 0", right_o); end
        vec++; if (ovf_o !== 1'b0) begin miss++; $display("FAIL rst_ovf got %b exp 0", ovf_o); end
        vec++; if (frm_err_o !== 1'b0) begin miss++; $display("FAIL rst_err got %b exp 0", frm_err_o); end
        vec++; if (lock_o !== 1'b0) begin miss++; $display("FAIL rst_lock got %b exp 0", lock_o); end
    endtask

    task automatic test_clean_stream();
        int b, e, v;
        rdy_i = 1'b1;
        b = acc_l.size(); e = err_cnt; v = vld_rises;
        for (int i = 0; i < SW; i++) send_bit(1'b1, 1'b0, 1'b0);
        send_frame(24'h7FFFFF, 24'h800001, SW, SW);
        send_frame(24'h7FFFFF, 24'h800001, SW, SW);
        vec++; if (lock_o !== 1'b1) begin miss++; $display("FAIL clean_lock_first got %b exp 1", lock_o); end
        send_frame(24'h7FFFFF, 24'h800001, SW, SW);
        close_frame(1'b0);
        repeat (2) @(posedge clk);
        #1;
        vec++; if (acc_l.size() - b !== 3) begin miss++; $display("FAIL clean_count got %0d exp 3", acc_l.size() - b); end
        vec++; if (vld_rises - v !== 3) begin miss++; $display("FAIL clean_vld_pulses got %0d exp 3", vld_rises - v); end
        vec++; if (err_cnt - e !== 0) begin miss++; $display("FAIL clean_err got %0d exp 0", err_cnt - e); end
        if (acc_l.size() >= b + 3) begin
            for (int i = b; i < b + 3; i++) begin
                vec++; if (acc_l[i] !== 24'h7FFFFF) begin miss++; $display("FAIL clean_left[%0d] got %h exp 7fffff", i - b, acc_l[i]); end
                vec++; if (acc_r[i] !== 24'h800001) begin miss++; $display("FAIL clean_right[%0d] got %h exp 800001", i - b, acc_r[i]); end
            end
        end
        vec++; if (vld_o !== 1'b0) begin miss++; $display("FAIL clean_vld_idle got %b exp 0", vld_o); end
    endtask

    task automatic test_backpressure();
        int b;
        rdy_i = 1'b0;
        b = acc_l.size();
        send_frame(24'h000001, 24'h100001, SW, SW);
        close_frame(1'b0);
        vec++; if (vld_o !== 1'b1) begin miss++; $display("FAIL bp_vld1 got %b exp 1", vld_o); end
        vec++; if (ovf_o !== 1'b0) begin miss++; $display("FAIL bp_ovf1 got %b exp 0", ovf_o); end
        send_frame(24'h000002, 24'h100002, SW, SW);
        close_frame(1'b0);
        vec++; if (ovf_o !== 1'b1) begin miss++; $display("FAIL bp_ovf2 got %b exp 1", ovf_o); end
        send_frame(24'h000003, 24'h100003, SW, SW);
        close_frame(1'b0);
        vec++; if (left_o !== 24'h000001) begin miss++; $display("FAIL bp_hold_left got %h exp 000001", left_o); end
        vec++; if (right_o !== 24'h100001) begin miss++; $display("FAIL bp_hold_right got %h exp 100001", right_o); end
        @(posedge clk);
        #1 rdy_i = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        vec++; if (acc_l.size() - b !== 1) begin miss++; $display("FAIL bp_acc_count got %0d exp 1", acc_l.size() - b); end
        if (acc_l.size() > b) begin
            vec++; if (acc_l[b] !== 24'h000001) begin miss++; $display("FAIL bp_acc_left got %h exp 000001", acc_l[b]); end
            vec++; if (acc_r[b] !== 24'h100001) begin miss++; $display("FAIL bp_acc_right got %h exp 100001", acc_r[b]); end
        end
        vec++; if (vld_o !== 1'b0) begin miss++; $display("FAIL bp_vld_drop got %b exp 0", vld_o); end
        vec++; if (ovf_o !== 1'b1) begin miss++; $display("FAIL bp_ovf_sticky got %b exp 1", ovf_o); end
        ovf_clr_i = 1'b1;
        @(posedge clk);
        #1 ovf_clr_i = 1'b0;
        vec++; if (ovf_o !== 1'b0) begin miss++; $display("FAIL bp_ovf_clr got %b exp 0", ovf_o); end
    endtask

    task automatic test_short_slot();
        int b, e;
        rdy_i = 1'b1;
        b = acc_l.size(); e = err_cnt;
        send_frame(24'h111111, 24'h222222, SW, SW - 1);
        close_frame(1'b0);
        repeat (2) @(posedge clk);
        #1;
        vec++; if (err_cnt - e !== 1) begin miss++; $display("FAIL short_err got %0d exp 1", err_cnt - e); end
        vec++; if (lock_o !== 1'b0) begin miss++; $display("FAIL short_lock got %b exp 0", lock_o); end
        vec++; if (acc_l.size() - b !== 0) begin miss++; $display("FAIL short_no_frame got %0d exp 0", acc_l.size() - b); end
        // Back in HUNT: a right slot precedes the next aligned left slot.
        open_left = 1'b0;
        for (int i = 0; i < SW; i++) send_bit(1'b1, 1'b1, 1'b0);
        send_frame(24'hABCDEF, 24'h012345, SW, SW);
        close_frame(1'b0);
        repeat (2) @(posedge clk);
        #1;
        vec++; if (acc_l.size() - b !== 1) begin miss++; $display("FAIL short_recover_count got %0d exp 1", acc_l.size() - b); end
        if (acc_l.size() > b) begin
            vec++; if (acc_l[b] !== 24'hABCDEF) begin miss++; $display("FAIL short_recover_left got %h exp abcdef", acc_l[b]); end
            vec++; if (acc_r[b] !== 24'h012345) begin miss++; $display("FAIL short_recover_right got %h exp 012345", acc_r[b]); end
        end
        vec++; if (err_cnt - e !== 1) begin miss++; $display("FAIL short_recover_err got %0d exp 1", err_cnt - e); end
        vec++; if (lock_o !== 1'b1) begin miss++; $display("FAIL short_relock got %b exp 1", lock_o); end
    endtask

    task automatic test_hunt_stuck();
        int b, e;
        rdy_i = 1'b1;
        apply_reset();
        b = acc_l.size(); e = err_cnt;
        for (int i = 0; i < 70; i++) send_bit(1'b1, 1'(i % 3 == 0), 1'b0);
        vec++; if (err_cnt - e !== 0) begin miss++; $display("FAIL hunt_err got %0d exp 0", err_cnt - e); end
        vec++; if (lock_o !== 1'b0) begin miss++; $display("FAIL hunt_lock got %b exp 0", lock_o); end
        send_frame(24'h3C3C3C, 24'hC3C3C3, SW, SW);
        close_frame(1'b0);
        repeat (2) @(posedge clk);
        #1;
        vec++; if (acc_l.size() - b !== 1) begin miss++; $display("FAIL hunt_count got %0d exp 1", acc_l.size() - b); end
        if (acc_l.size() > b) begin
            vec++; if (acc_l[b] !== 24'h3C3C3C) begin miss++; $display("FAIL hunt_left got %h exp 3c3c3c", acc_l[b]); end
            vec++; if (acc_r[b] !== 24'hC3C3C3) begin miss++; $display("FAIL hunt_right got %h exp c3c3c3", acc_r[b]); end
        end
        vec++; if (err_cnt - e !== 0) begin miss++; $display("FAIL hunt_err_after got %0d exp 0", err_cnt - e); end
        vec++; if (lock_o !== 1'b1) begin miss++; $display("FAIL hunt_lock_after got %b exp 1", lock_o); end
    endtask

    task automatic test_back_to_back();
        int b;
        rdy_i = 1'b0;
        b = acc_l.size();
        send_frame(24'hAAAAAA, 24'h555555, SW, SW);
        close_frame(1'b0);
        vec++; if (vld_o !== 1'b1) begin miss++; $display("FAIL b2b_vld_a got %b exp 1", vld_o); end
        send_frame(24'h0F0F0F, 24'hF0F0F0, SW, SW);
        close_frame(1'b1);
        vec++; if (vld_o !== 1'b1) begin miss++; $display("FAIL b2b_vld_b got %b exp 1", vld_o); end
        vec++; if (left_o !== 24'h0F0F0F) begin miss++; $display("FAIL b2b_left_b got %h exp 0f0f0f", left_o); end
        vec++; if (right_o !== 24'hF0F0F0) begin miss++; $display("FAIL b2b_right_b got %h exp f0f0f0", right_o); end
        vec++; if (ovf_o !== 1'b0) begin miss++; $display("FAIL b2b_ovf got %b exp 0", ovf_o); end
        vec++; if (acc_l.size() - b !== 1) begin miss++; $display("FAIL b2b_acc_a_count got %0d exp 1", acc_l.size() - b); end
        if (acc_l.size() > b) begin
            vec++; if (acc_l[b] !== 24'hAAAAAA) begin miss++; $display("FAIL b2b_acc_a got %h exp aaaaaa", acc_l[b]); end
        end
        rdy_i = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        vec++; if (acc_l.size() - b !== 2) begin miss++; $display("FAIL b2b_acc_b_count got %0d exp 2", acc_l.size() - b); end
        if (acc_r.size() > b + 1) begin
            vec++; if (acc_r[b+1] !== 24'hF0F0F0) begin miss++; $display("FAIL b2b_acc_b got %h exp f0f0f0", acc_r[b+1]); end
        end
    endtask

    task automatic test_reset_mid();
        int b;
        logic [DW-1:0] pat;
        rdy_i = 1'b1;
        pat = 24'h9E3779;
        // Bits 1..10 of a left slot (bit 0 was the preceding close).
        for (int i = 1; i <= 10; i++) send_bit(1'b0, pat[DW-i], 1'b0);
        vec++; if (left_o !== 24'h0F0F0F) begin miss++; $display("FAIL mid_pre_left got %h exp 0f0f0f", left_o); end
        rst_n = 1'b0;
        #1;
        vec++; if (left_o !== '0) begin miss++; $display("FAIL mid_rst_left got %h exp 0", left_o); end
        vec++; if (right_o !== '0) begin miss++; $display("FAIL mid_rst_right got %h exp 0", right_o); end
        vec++; if (vld_o !== 1'b0) begin miss++; $display("FAIL mid_rst_vld got %b exp 0", vld_o); end
        vec++; if (lock_o !== 1'b0) begin miss++; $display("FAIL mid_rst_lock got %b exp 0", lock_o); end
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        open_left = 1'b0;
        b = acc_l.size();
        for (int i = 11; i < SW; i++) send_bit(1'b0, (i <= DW) ? pat[DW-i] : 1'b0, 1'b0);
        for (int i = 0; i < SW; i++) send_bit(1'b1, 1'b1, 1'b0);
        vec++; if (acc_l.size() - b !== 0) begin miss++; $display("FAIL mid_no_early got %0d exp 0", acc_l.size() - b); end
        send_frame(24'h123456, 24'h654321, SW, SW);
        close_frame(1'b0);
        repeat (2) @(posedge clk);
        #1;
        vec++; if (acc_l.size() - b !== 1) begin miss++; $display("FAIL mid_count got %0d exp 1", acc_l.size() - b); end
        if (acc_l.size() > b) begin
            vec++; if (acc_l[b] !== 24'h123456) begin miss++; $display("FAIL mid_left got %h exp 123456", acc_l[b]); end
            vec++; if (acc_r[b] !== 24'h654321) begin miss++; $display("FAIL mid_right got %h exp 654321", acc_r[b]); end
        end
    endtask

    initial begin
        rst_n = 1'b1;
        test_reset();
        test_clean_stream();
        test_backpressure();
        test_short_slot();
        test_hunt_stuck();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule
